// File: rtl/xy_move_sequencer.sv
// Two-axis move sequencer: takes an absolute (x, y) target or a home request,
// runs the X controller then the Y controller, and tracks the resulting position.
module xy_move_sequencer #(
  parameter int                STEP_W  = 12,
  parameter logic [STEP_W-1:0] X_MAX   = STEP_W'(2000),
  parameter logic [STEP_W-1:0] Y_MAX   = STEP_W'(2000),
  parameter logic [31:0]       TIMEOUT = 32'd50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_home,
  input  logic [STEP_W-1:0] cmd_x,
  input  logic [STEP_W-1:0] cmd_y,
  output logic              x_go,
  output logic              x_dir,
  output logic [STEP_W-1:0] x_steps,
  input  logic              x_done,
  output logic              y_go,
  output logic              y_dir,
  output logic [STEP_W-1:0] y_steps,
  input  logic              y_done,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              fault,
  output logic              homed,
  output logic [STEP_W-1:0] pos_x,
  output logic [STEP_W-1:0] pos_y,
  output logic [2:0]        state_dbg
);

  // Command handshake: a command transfers on the rising edge where
  // cmd_valid && cmd_ready; cmd_ready is high only in IDLE, and a rejected
  // command still transfers (it is consumed and answered with an err pulse).

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_X_MOVE = 3'd2,
    S_X_GAP  = 3'd3,
    S_Y_MOVE = 3'd4,
    S_Y_GAP  = 3'd5,
    S_FIN    = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  state_t            state;
  logic              home_q;
  logic [STEP_W-1:0] tgt_x;
  logic [STEP_W-1:0] tgt_y;
  logic [31:0]       tmr;

  logic              x_back;
  logic              y_back;
  logic [STEP_W-1:0] x_delta;
  logic [STEP_W-1:0] y_delta;
  logic              ld_x_dir;
  logic              ld_y_dir;
  logic [STEP_W-1:0] ld_x_steps;
  logic [STEP_W-1:0] ld_y_steps;
  logic              reject;
  logic              timeout_hit;

  assign state_dbg = state;

  // Both target and position are bounded by MAX, so the subtraction cannot wrap.
  always_comb begin
    x_back      = tgt_x < pos_x;
    y_back      = tgt_y < pos_y;
    x_delta     = x_back ? (pos_x - tgt_x) : (tgt_x - pos_x);
    y_delta     = y_back ? (pos_y - tgt_y) : (tgt_y - pos_y);
    ld_x_dir    = home_q | x_back;
    ld_y_dir    = home_q | y_back;
    ld_x_steps  = home_q ? X_MAX : x_delta;
    ld_y_steps  = home_q ? Y_MAX : y_delta;
    reject      = !cmd_home && (!homed || (cmd_x > X_MAX) || (cmd_y > Y_MAX));
    timeout_hit = (tmr + 32'd1) == TIMEOUT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      home_q    <= 1'b0;
      tgt_x     <= '0;
      tgt_y     <= '0;
      tmr       <= '0;
      cmd_ready <= 1'b1;
      x_go      <= 1'b0;
      x_dir     <= 1'b0;
      x_steps   <= '0;
      y_go      <= 1'b0;
      y_dir     <= 1'b0;
      y_steps   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      fault     <= 1'b0;
      homed     <= 1'b0;
      pos_x     <= '0;
      pos_y     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (reject) begin
              err <= 1'b1;
            end else begin
              home_q    <= cmd_home;
              tgt_x     <= cmd_home ? '0 : cmd_x;
              tgt_y     <= cmd_home ? '0 : cmd_y;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
              state     <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          // go is raised here so X_MOVE sees it on its first cycle; zero steps skips the axis
          x_dir   <= ld_x_dir;
          x_steps <= ld_x_steps;
          y_dir   <= ld_y_dir;
          y_steps <= ld_y_steps;
          x_go    <= ld_x_steps != '0;
          tmr     <= '0;
          state   <= S_X_MOVE;
        end
        S_X_MOVE: begin
          if (!x_go) begin
            state <= S_X_GAP;
          end else if (x_done) begin
            x_go  <= 1'b0;
            pos_x <= tgt_x;
            state <= S_X_GAP;
          end else if (timeout_hit) begin
            x_go  <= 1'b0;
            fault <= 1'b1;
            homed <= 1'b0;
            busy  <= 1'b0;
            state <= S_FAULT;
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        S_X_GAP: begin
          y_go  <= y_steps != '0;
          tmr   <= '0;
          state <= S_Y_MOVE;
        end
        S_Y_MOVE: begin
          if (!y_go) begin
            state <= S_Y_GAP;
          end else if (y_done) begin
            y_go  <= 1'b0;
            pos_y <= tgt_y;
            state <= S_Y_GAP;
          end else if (timeout_hit) begin
            y_go  <= 1'b0;
            fault <= 1'b1;
            homed <= 1'b0;
            busy  <= 1'b0;
            state <= S_FAULT;
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        S_Y_GAP: begin
          state <= S_FIN;
        end
        S_FIN: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          if (home_q) homed <= 1'b1;
          state <= S_IDLE;
        end
        S_FAULT: begin
          // only reset leaves this state
          cmd_ready <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xy_move_sequencer.sv
// Directed bench for xy_move_sequencer: a vector table of commands with
// hand-computed axis outputs and positions, plus timeout and reset sequences.
module tb_xy_move_sequencer;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_home = 1'b0;
  logic [W-1:0] cmd_x = '0;
  logic [W-1:0] cmd_y = '0;
  logic         x_go, x_dir, y_go, y_dir;
  logic [W-1:0] x_steps, y_steps;
  logic         x_done = 1'b0;
  logic         y_done = 1'b0;
  logic         busy, done, err, fault, homed;
  logic [W-1:0] pos_x, pos_y;
  logic [2:0]   state_dbg;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic         home;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         e_err;
    logic         e_xgo;
    logic         e_xdir;
    logic [W-1:0] e_xsteps;
    logic         e_ygo;
    logic         e_ydir;
    logic [W-1:0] e_ysteps;
    logic [W-1:0] e_px;
    logic [W-1:0] e_py;
    logic         e_homed;
  } vec_t;

  vec_t vecs[8];

  // clock / reset
  always #5 clk = ~clk;

  xy_move_sequencer #(
    .STEP_W(W), .X_MAX(12'd2000), .Y_MAX(12'd2000), .TIMEOUT(32'd20)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_home(cmd_home),
    .cmd_x(cmd_x), .cmd_y(cmd_y),
    .x_go(x_go), .x_dir(x_dir), .x_steps(x_steps), .x_done(x_done),
    .y_go(y_go), .y_dir(y_dir), .y_steps(y_steps), .y_done(y_done),
    .busy(busy), .done(done), .err(err), .fault(fault), .homed(homed),
    .pos_x(pos_x), .pos_y(pos_y), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic apply_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    x_done    = 1'b0;
    y_done    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_cmd(input logic home, input logic [W-1:0] x, input logic [W-1:0] y);
    cmd_valid = 1'b1;
    cmd_home  = home;
    cmd_x     = x;
    cmd_y     = y;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_go"}, {x_go, y_go}, 0);
    check({tag, "_dir_steps"}, {x_dir, y_dir, x_steps, y_steps}, 0);
    check({tag, "_flags"}, {busy, done, err, fault, homed}, 0);
    check({tag, "_pos"}, {pos_x, pos_y}, 0);
  endtask

  // Applies one vector; the bench acts as both motor controllers, pulsing done
  // on the 5th cycle it sees go high.
  task automatic run_vec(input vec_t v, input int idx);
    string        tag;
    logic         xg_seen, yg_seen, x_dir0, y_dir0, stable;
    logic [W-1:0] x_steps0, y_steps0;
    int           last_x_k, first_y_k, done_k, done_cnt, xcnt, ycnt, limit;
    logic [2*W-1:0] e;
    tag = $sformatf("v%0d", idx);
    xg_seen = 0; yg_seen = 0; stable = 1;
    x_dir0 = 0; y_dir0 = 0; x_steps0 = '0; y_steps0 = '0;
    last_x_k = -1; first_y_k = -1; done_k = -1; done_cnt = 0; xcnt = 0; ycnt = 0;
    limit = v.e_err ? 10 : 100;
    send_cmd(v.home, v.x, v.y);
    check({tag, "_err"}, err, v.e_err);
    check({tag, "_ready_after_accept"}, cmd_ready, v.e_err);
    if (!v.e_err) exp_q.push_back({v.e_px, v.e_py});
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (k == 1) check({tag, "_err_one_cycle"}, err, 0);
      if (x_go) begin
        if (!xg_seen) begin
          x_dir0 = x_dir; x_steps0 = x_steps;
        end else if (x_dir !== x_dir0 || x_steps !== x_steps0) begin
          stable = 0;
        end
        xg_seen = 1; last_x_k = k; xcnt++;
      end
      if (y_go) begin
        if (!yg_seen) begin
          y_dir0 = y_dir; y_steps0 = y_steps; first_y_k = k;
        end else if (y_dir !== y_dir0 || y_steps !== y_steps0) begin
          stable = 0;
        end
        yg_seen = 1; ycnt++;
      end
      x_done = x_go && (xcnt == 5);
      y_done = y_go && (ycnt == 5);
      if (done) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = k;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_sb_pos"}, {pos_x, pos_y}, e);
          end else begin
            check({tag, "_sb_unexpected_done"}, exp_q.size(), 1);
          end
        end
      end
      if (done_k >= 0 && k >= done_k + 1) break;
    end
    x_done = 1'b0;
    y_done = 1'b0;
    if (!v.e_err && done_k < 0) check({tag, "_done_timeout"}, done_cnt, 1);
    check({tag, "_x_go_seen"}, xg_seen, v.e_xgo);
    if (v.e_xgo) check({tag, "_x_dir_steps"}, {x_dir0, x_steps0}, {v.e_xdir, v.e_xsteps});
    check({tag, "_y_go_seen"}, yg_seen, v.e_ygo);
    if (v.e_ygo) check({tag, "_y_dir_steps"}, {y_dir0, y_steps0}, {v.e_ydir, v.e_ysteps});
    check({tag, "_dir_steps_stable"}, stable, 1);
    check({tag, "_done_count"}, done_cnt, v.e_err ? 0 : 1);
    if (v.e_xgo && v.e_ygo) check({tag, "_gap_before_y_go"}, (first_y_k - last_x_k) >= 2, 1);
    if (!v.e_err && !v.e_xgo && !v.e_ygo) check({tag, "_zero_move_latency"}, done_k, 6);
    check({tag, "_pos"}, {pos_x, pos_y}, {v.e_px, v.e_py});
    check({tag, "_homed"}, homed, v.e_homed);
  endtask

  initial begin
    logic stray_bad;
    int   go_cycles;
    logic y_seen;

    //        home  x        y        err   xgo   xdir  xsteps    ygo   ydir  ysteps    px       py       homed
    vecs[0] = '{1'b0, 12'd10,   12'd10,   1'b1, 1'b0, 1'b0, 12'd0,    1'b0, 1'b0, 12'd0,    12'd0,   12'd0,    1'b0};
    vecs[1] = '{1'b1, 12'd77,   12'd99,   1'b0, 1'b1, 1'b1, 12'd2000, 1'b1, 1'b1, 12'd2000, 12'd0,   12'd0,    1'b1};
    vecs[2] = '{1'b0, 12'd300,  12'd0,    1'b0, 1'b1, 1'b0, 12'd300,  1'b0, 1'b0, 12'd0,    12'd300, 12'd0,    1'b1};
    vecs[3] = '{1'b0, 12'd100,  12'd50,   1'b0, 1'b1, 1'b1, 12'd200,  1'b1, 1'b0, 12'd50,   12'd100, 12'd50,   1'b1};
    vecs[4] = '{1'b0, 12'd2001, 12'd5,    1'b1, 1'b0, 1'b0, 12'd0,    1'b0, 1'b0, 12'd0,    12'd100, 12'd50,   1'b1};
    vecs[5] = '{1'b0, 12'd100,  12'd50,   1'b0, 1'b0, 1'b0, 12'd0,    1'b0, 1'b0, 12'd0,    12'd100, 12'd50,   1'b1};
    vecs[6] = '{1'b0, 12'd0,    12'd2000, 1'b0, 1'b1, 1'b1, 12'd100,  1'b1, 1'b0, 12'd1950, 12'd0,   12'd2000, 1'b1};
    vecs[7] = '{1'b0, 12'd5,    12'd2001, 1'b1, 1'b0, 1'b0, 12'd0,    1'b0, 1'b0, 12'd0,    12'd0,   12'd2000, 1'b1};

    apply_reset();
    check_reset_state("reset0");

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // stray done pulses in IDLE must not move the tracked position
    stray_bad = 0;
    for (int k = 0; k < 6; k++) begin
      x_done = 1'b1;
      y_done = (k % 2) == 0;
      tick();
      if (done || x_go || y_go) stray_bad = 1;
    end
    x_done = 1'b0;
    y_done = 1'b0;
    tick();
    check("stray_no_done_no_go", stray_bad, 0);
    check("stray_pos", {pos_x, pos_y}, {12'd0, 12'd2000});

    // X controller never answers: go must drop after exactly 20 cycles
    send_cmd(1'b0, 12'd1000, 12'd500);
    go_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (x_go) begin
        go_cycles++;
        if (go_cycles == 1) check("to_x_dir_steps", {x_dir, x_steps}, {1'b0, 12'd1000});
      end
    end
    check("to_go_cycles", go_cycles, 20);
    check("to_fault", fault, 1);
    check("to_homed", homed, 0);
    check("to_ready_busy", {cmd_ready, busy}, 0);
    check("to_state", state_dbg, 7);
    cmd_valid = 1'b1;
    cmd_home  = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    cmd_valid = 1'b0;
    cmd_home  = 1'b0;
    check("fault_sticky", {fault, cmd_ready, x_go, y_go}, 4'b1000);

    apply_reset();
    check_reset_state("reset1");

    // rehome, then reset while the Y axis is moving
    run_vec(vecs[1], 8);
    send_cmd(1'b0, 12'd0, 12'd300);
    y_seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (y_go) begin
        y_seen = 1;
        break;
      end
    end
    check("midy_y_go_seen", y_seen, 1);
    check("midy_x_skipped", x_go, 0);
    check("midy_y_dir_steps", {y_dir, y_steps}, {1'b0, 12'd300});
    reset = 1'b1;
    tick();
    check("midy_y_go_dropped", y_go, 0);
    check("midy_homed", homed, 0);
    check("midy_ready_busy", {cmd_ready, busy}, 2'b10);
    reset = 1'b0;
    tick();
    check("midy_still_idle", {y_go, busy, cmd_ready}, 3'b001);

    check("sb_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
